mac_operand_feeder: RTL

- Upstream stage of the MAC datapath inside the MFCC/CNN accelerator subsystem.
- Streams two operand vectors out of local SRAM and drives simple_mac's data_a/data_b/valid/clear inputs, with one pair per cycle.
- Replaces CPU word-by-word writes over AHB for long dot products such as filterbank weights × spectrum, or kernel × feature window.
- Control inputs come from a register block, which owns the start, abort and status bits.

---
 rtl/mac_feeder_pkg.sv | 21 ++
 rtl/feeder_addr_gen.sv | 39 +++
 rtl/mac_operand_feeder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mac_feeder_pkg.sv
// Shared types and constants for the MAC operand feeder.
// Holds the FSM state encoding, drain depth and default widths.
package mac_feeder_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int LEN_W_DEF  = 12;
  localparam int DATA_W_DEF = 32;

  // SRAM read latency plus the operand output register
  localparam int PIPE_DEPTH  = 2;
  localparam int DRAIN_CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;

endpackage

// File: rtl/feeder_addr_gen.sv
// Per-port read address generator: latched base, issue index and wrapping adder.
// last is high once every index below len has been issued.
module feeder_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              issue,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  idx_reg;
  logic [ADDR_W-1:0] addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg <= '0;
      idx_reg  <= '0;
      addr_reg <= '0;
    end else if (load) begin
      base_reg <= base;
      idx_reg  <= '0;
    end else if (issue) begin
      // sum is truncated to ADDR_W bits, so it wraps past the top of SRAM
      addr_reg <= base_reg + ADDR_W'(idx_reg);
      idx_reg  <= idx_reg + LEN_W'(1);
    end
  end

  assign addr = addr_reg;
  assign last = (idx_reg == len);

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams operand pairs from two SRAM ports into simple_mac, one pair per cycle.
// Outputs are registered from the next-state decision so they line up with the state.
module mac_operand_feeder
  import mac_feeder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              hclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_a_en,
  output logic [ADDR_W-1:0] mem_a_addr,
  input  logic [DATA_W-1:0] mem_a_rdata,
  output logic              mem_b_en,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [DATA_W-1:0] mem_b_rdata,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              data_a_valid,
  output logic              data_b_valid,
  output logic              clear
);

  feeder_state_e state_reg, state_next;

  logic [LEN_W-1:0]       len_reg;
  logic [DRAIN_CNT_W-1:0] drain_cnt_reg;
  logic                   load;
  logic                   issue;
  logic                   last_a;
  logic                   last_b_unused;

  logic              busy_reg;
  logic              done_reg;
  logic              clear_reg;
  logic              mem_en_reg;
  logic              rd_pend_reg;
  logic              valid_reg;
  logic [DATA_W-1:0] data_a_reg;
  logic [DATA_W-1:0] data_b_reg;

  // abort overrides every transition, including a start seen in IDLE
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    issue      = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            load       = 1'b1;
            state_next = ST_CLR;
          end
        end
        ST_CLR: begin
          if (len_reg == '0) begin
            state_next = ST_DRAIN;
          end else begin
            issue      = 1'b1;
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (last_a) begin
            state_next = ST_DRAIN;
          end else begin
            issue = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == DRAIN_CNT_W'(PIPE_DEPTH - 1)) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      drain_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      clear_reg     <= 1'b0;
      mem_en_reg    <= 1'b0;
      rd_pend_reg   <= 1'b0;
      valid_reg     <= 1'b0;
      data_a_reg    <= '0;
      data_b_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      if (load) begin
        len_reg <= len;
      end
      drain_cnt_reg <= (state_reg == ST_DRAIN) ? drain_cnt_reg + DRAIN_CNT_W'(1) : '0;
      busy_reg      <= (state_next != ST_IDLE);
      done_reg      <= (state_next == ST_DONE);
      clear_reg     <= (state_next == ST_CLR);
      mem_en_reg    <= issue;
      // rd_pend marks the cycle the SRAM data is on mem_*_rdata
      rd_pend_reg   <= mem_en_reg & ~abort;
      valid_reg     <= rd_pend_reg & ~abort;
      if (rd_pend_reg && !abort) begin
        data_a_reg <= mem_a_rdata;
        data_b_reg <= mem_b_rdata;
      end
    end
  end

  feeder_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_a (
    .clk   (hclk),
    .rst_n (rst_n),
    .load  (load),
    .base  (base_a),
    .issue (issue),
    .len   (len_reg),
    .addr  (mem_a_addr),
    .last  (last_a)
  );

  feeder_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_b (
    .clk   (hclk),
    .rst_n (rst_n),
    .load  (load),
    .base  (base_b),
    .issue (issue),
    .len   (len_reg),
    .addr  (mem_b_addr),
    .last  (last_b_unused)
  );

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign clear        = clear_reg;
  assign mem_a_en     = mem_en_reg;
  assign mem_b_en     = mem_en_reg;
  assign data_a       = data_a_reg;
  assign data_b       = data_b_reg;
  assign data_a_valid = valid_reg;
  assign data_b_valid = valid_reg;

endmodule
